// File: rtl/mac_decap_if.sv
// rtl/mac_decap_if.sv - byte stream carrying decapsulated receive frames
interface mac_decap_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/mac_decap.sv
// rtl/mac_decap.sv - GMII receive decapsulator: preamble strip, DA filter, FCS check and strip
module mac_decap #(
  parameter int MIN_PAYLOAD_LENGTH = 46,
  parameter int MAX_PAYLOAD_LENGTH = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  input  logic [47:0] mac_address,
  input  logic        promiscuous,
  input  logic        accept_multicast,
  mac_decap_if.master stream,
  output logic        rx_good_frame,
  output logic        rx_bad_frame,
  output logic        rx_filtered
);
  localparam logic [10:0] RUNT_LIMIT     = 11'(MIN_PAYLOAD_LENGTH + 18);
  localparam logic [10:0] OVERSIZE_COUNT = 11'(MAX_PAYLOAD_LENGTH + 19);
  localparam logic [10:0] DA_COUNT       = 11'd6;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state;
  logic [4:0][7:0] line;
  logic [10:0]     count;
  logic [31:0]     crc;
  logic            rxer_seen;

  logic [10:0]     count_next;
  logic [31:0]     crc_next;
  logic            da_accept;
  logic            frame_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // {line, gmii_rxd} is the full DA at the moment DA byte 5 is on the bus
  always_comb begin
    count_next = (count == '1) ? count : count + 11'd1;
    crc_next   = crc_byte(crc, gmii_rxd);
    da_accept  = promiscuous || ({line, gmii_rxd} == mac_address) ||
                 (&{line, gmii_rxd}) || (line[4][0] && accept_multicast);
    frame_bad  = (crc != CRC_RESIDUE) || rxer_seen || (count < RUNT_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      line          <= '0;
      count         <= '0;
      crc           <= '1;
      rxer_seen     <= 1'b0;
      stream.tdata  <= 8'h00;
      stream.tvalid <= 1'b0;
      stream.tlast  <= 1'b0;
      stream.tuser  <= 1'b0;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      rx_filtered   <= 1'b0;
    end else begin
      stream.tvalid <= 1'b0;
      stream.tlast  <= 1'b0;
      stream.tuser  <= 1'b0;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      rx_filtered   <= 1'b0;
      if (clk_enable) begin
        if (state != DATA) begin
          count     <= '0;
          crc       <= '1;
          rxer_seen <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (gmii_rxdv) begin
              if (gmii_rxd == 8'h55)      state <= PREAMBLE;
              else if (gmii_rxd == 8'hD5) state <= DATA;
              else                        state <= DROP;
            end
          end
          PREAMBLE: begin
            if (!gmii_rxdv)                 state <= IDLE;
            else if (gmii_rxd == 8'hD5)     state <= DATA;
            else if (gmii_rxd != 8'h55)     state <= DROP;
          end
          DATA: begin
            if (gmii_rxdv) begin
              line      <= {line[3:0], gmii_rxd};
              crc       <= crc_next;
              count     <= count_next;
              rxer_seen <= rxer_seen | gmii_rxer;
              if (count_next == DA_COUNT && !da_accept) begin
                rx_filtered <= 1'b1;
                state       <= DROP;
              end else if (count_next == OVERSIZE_COUNT) begin
                stream.tvalid <= 1'b1;
                stream.tdata  <= line[4];
                stream.tlast  <= 1'b1;
                stream.tuser  <= 1'b1;
                rx_bad_frame  <= 1'b1;
                state         <= DROP;
              end else if (count_next >= DA_COUNT) begin
                stream.tvalid <= 1'b1;
                stream.tdata  <= line[4];
              end
            end else begin
              // the four newest bytes in the line are the FCS and are discarded
              if (count >= DA_COUNT) begin
                stream.tvalid <= 1'b1;
                stream.tdata  <= line[4];
                stream.tlast  <= 1'b1;
                stream.tuser  <= frame_bad;
                rx_good_frame <= ~frame_bad;
                rx_bad_frame  <= frame_bad;
              end
              state <= IDLE;
            end
          end
          DROP: begin
            if (!gmii_rxdv) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_decap.sv
// tb/tb_mac_decap.sv - randomized self-checking bench for mac_decap against a frame-level model
module tb_mac_decap;
  localparam int MIN_PL = 46;
  localparam int MAX_PL = 1500;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [7:0]  gmii_rxd;
  logic        gmii_rxdv;
  logic        gmii_rxer;
  logic [47:0] mac_address;
  logic        promiscuous;
  logic        accept_multicast;
  logic        rx_good_frame;
  logic        rx_bad_frame;
  logic        rx_filtered;

  mac_decap_if stream_if();

  mac_decap #(.MIN_PAYLOAD_LENGTH(MIN_PL), .MAX_PAYLOAD_LENGTH(MAX_PL)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_enable       (clk_enable),
    .gmii_rxd         (gmii_rxd),
    .gmii_rxdv        (gmii_rxdv),
    .gmii_rxer        (gmii_rxer),
    .mac_address      (mac_address),
    .promiscuous      (promiscuous),
    .accept_multicast (accept_multicast),
    .stream           (stream_if),
    .rx_good_frame    (rx_good_frame),
    .rx_bad_frame     (rx_bad_frame),
    .rx_filtered      (rx_filtered)
  );

  always #4 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  int         div = 1;
  int         cyc = 0;
  int         prev_cyc = 0;
  bit         in_frame = 0;
  int         beats = 0;
  int         good_seen = 0;
  int         bad_seen = 0;
  int         filt_seen = 0;
  int         exp_filt = 0;
  beat_t      exp_q[$];
  logic [7:0] frame[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] d[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
    return b;
  endfunction

  task automatic build(input logic [47:0] da, input int plen, input bit good_fcs);
    logic [31:0] f;
    int          k;
    int          bitn;
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame.push_back(rnd_byte());
    frame.push_back(8'h08);
    frame.push_back(8'h00);
    for (int i = 0; i < plen; i++) frame.push_back(rnd_byte());
    f = crc32(frame, frame.size());
    for (int i = 0; i < 4; i++) frame.push_back(f[8*i +: 8]);
    if (!good_fcs) begin
      k = (plen > 0) ? 14 + int'($urandom_range(0, plen - 1)) : 6;
      bitn = int'($urandom_range(0, 7));
      frame[k][bitn] = ~frame[k][bitn];
    end
  endtask

  // Frame-level expectation: FCS stripped, delivered bytes are DA..payload
  task automatic model(input bit er);
    int          n;
    logic [47:0] da;
    logic [31:0] fcs;
    bit          bad;
    n = frame.size();
    if (n < 6) return;
    da = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
    if (!(promiscuous || da == mac_address || da == 48'hFFFF_FFFF_FFFF ||
          (frame[0][0] && accept_multicast))) begin
      exp_filt++;
      return;
    end
    if (n >= MAX_PL + 19) begin
      for (int i = 0; i < MAX_PL + 14; i++)
        exp_q.push_back('{frame[i], i == MAX_PL + 13, i == MAX_PL + 13});
      return;
    end
    fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
    bad = (crc32(frame, n - 4) != fcs) || er || (n < MIN_PL + 18);
    for (int i = 0; i <= n - 5; i++)
      exp_q.push_back('{frame[i], i == n - 5, (i == n - 5) && bad});
  endtask

  task automatic put(input logic dv, input logic [7:0] d, input logic er);
    gmii_rxdv = dv;
    gmii_rxd  = d;
    gmii_rxer = er;
    for (int k = 0; k < div; k++) begin
      clk_enable = (k == div - 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int pre, input int er_idx, input int rst_idx);
    if (pre == 0) begin
      repeat (7) put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'hD5, 1'b0);
    end else if (pre == 1) begin
      put(1'b1, 8'hD5, 1'b0);
    end else begin
      put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'h12, 1'b0);
    end
    for (int i = 0; i < frame.size(); i++) begin
      if (i == rst_idx) begin
        reset = 1'b1;
        exp_q.delete();
        put(1'b1, frame[i], 1'b0);
        reset = 1'b0;
      end else begin
        put(1'b1, frame[i], i == er_idx);
      end
    end
    repeat (12) put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_counts();
    beats = 0;
    good_seen = 0;
    bad_seen = 0;
  endtask

  task automatic frame_end();
    check("pending_beats", exp_q.size(), 0);
    check("filtered_count", filt_seen, exp_filt);
    exp_q.delete();
  endtask

  task automatic run_frame(input int pre, input int er_idx);
    clear_counts();
    if (pre != 2) model(er_idx >= 0 && er_idx < frame.size());
    send(pre, er_idx, -1);
    frame_end();
  endtask

  initial begin
    beat_t e;
    bit    eg;
    bit    eb;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_frame = 0;
      end else begin
        eg = 0;
        eb = 0;
        if (stream_if.tvalid) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("tdata", stream_if.tdata, e.data);
            check("tlast", stream_if.tlast, e.last);
            check("tuser", stream_if.tuser, e.user);
            eg = e.last && !e.user;
            eb = e.last && e.user;
          end
          if (div == 10 && in_frame) check("beat_spacing", cyc - prev_cyc, 10);
          prev_cyc = cyc;
          in_frame = !stream_if.tlast;
        end
        check("rx_good_frame", rx_good_frame, eg);
        check("rx_bad_frame", rx_bad_frame, eb);
        if (rx_good_frame) good_seen++;
        if (rx_bad_frame) bad_seen++;
        if (rx_filtered) filt_seen++;
      end
    end
  end

  initial begin
    logic [7:0]  pin[$];
    logic [47:0] da;
    int          kind;
    int          pre;
    int          er_idx;
    reset = 1'b1;
    clk_enable = 1'b0;
    gmii_rxd = 8'h00;
    gmii_rxdv = 1'b0;
    gmii_rxer = 1'b0;
    mac_address = 48'h00_1B_21_3C_4D_5E;
    promiscuous = 1'b0;
    accept_multicast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", stream_if.tvalid, 0);
    check("reset_tlast", stream_if.tlast, 0);
    check("reset_tuser", stream_if.tuser, 0);
    check("reset_good", rx_good_frame, 0);
    check("reset_bad", rx_bad_frame, 0);
    check("reset_filtered", rx_filtered, 0);
    for (int i = 0; i < 9; i++) pin.push_back(8'h31 + 8'(i));
    check("crc_model_pin", crc32(pin, 9), 32'hCBF43926);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    build(mac_address, 46, 1);
    run_frame(0, -1);
    check("good64_beats", beats, 60);
    check("good64_good", good_seen, 1);

    build(mac_address, 46, 0);
    run_frame(0, -1);
    check("crcerr_beats", beats, 60);
    check("crcerr_bad", bad_seen, 1);

    build(48'h02_00_00_00_00_01, 46, 1);
    run_frame(0, -1);
    check("filter_beats", beats, 0);
    check("filter_pulse", filt_seen, 1);

    promiscuous = 1'b1;
    run_frame(0, -1);
    check("promisc_beats", beats, 60);
    check("promisc_good", good_seen, 1);
    promiscuous = 1'b0;

    build(48'hFFFF_FFFF_FFFF, 22, 1);
    run_frame(0, -1);
    check("runt_beats", beats, 36);
    check("runt_bad", bad_seen, 1);

    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(mac_address[47-8*i -: 8]);
    for (int i = 6; i < 1530; i++) frame.push_back(rnd_byte());
    run_frame(0, -1);
    check("oversize_beats", beats, 1514);
    check("oversize_bad", bad_seen, 1);

    div = 10;
    build(mac_address, 46, 1);
    run_frame(0, -1);
    check("m100_beats", beats, 60);
    check("m100_good", good_seen, 1);

    build(mac_address, 100, 1);
    clear_counts();
    model(0);
    send(0, -1, 30);
    frame_end();
    check("reset_mid_good", good_seen, 0);
    check("reset_mid_bad", bad_seen, 0);

    build(mac_address, 46, 1);
    run_frame(0, -1);
    check("after_reset_good", good_seen, 1);

    for (int t = 0; t < 40; t++) begin
      div = ($urandom_range(0, 3) == 0) ? 10 : 1;
      promiscuous = ($urandom_range(0, 3) == 0);
      accept_multicast = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: da = mac_address;
        1: da = 48'hFFFF_FFFF_FFFF;
        2: da = 48'h01_00_5E_00_00_01;
        default: da = {7'($urandom), 1'b0, 40'($urandom) << 8 | 40'($urandom)};
      endcase
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        frame.delete();
        repeat ($urandom_range(1, 5)) frame.push_back(rnd_byte());
      end else begin
        build(da, int'($urandom_range(0, (div == 10) ? 50 : 90)), $urandom_range(0, 3) != 0);
      end
      pre = int'($urandom_range(0, 5));
      pre = (pre < 4) ? 0 : pre - 3;
      er_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, frame.size() - 1)) : -1;
      run_frame(pre, er_idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
